// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Definitions shared by the button conditioning block: the debounce FSM state
// encoding, the default debounce length and a constant clog2 helper used to size
// each channel's debounce counter.
// -----------------------------------------------------------------------------
package button_pkg;

    // Default debounce length in clk samples (about 2.5 ms at 100 MHz).
    localparam int unsigned DB_CYCLES_DEFAULT = 250000;
    localparam int unsigned NUM_BTN_DEFAULT   = 3;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_WAIT_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_WAIT_LO   = 2'd3
    } state_e;

    // Ceiling log2. A counter of f_clog2(n) bits can hold every value 0..n-1.
    function automatic int unsigned f_clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One button channel: a 2-FF synchroniser followed by a 4-state debounce FSM
// with a saturating counter and a press-toggled state bit.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_reset   synchronous active-high reset
//   i_raw     raw asynchronous button input
//   o_level   debounced level
//   o_rise    1-cycle pulse when o_level goes 0->1
//   o_fall    1-cycle pulse when o_level goes 1->0
//   o_toggle  flips on every accepted press
// -----------------------------------------------------------------------------
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_toggle
);

    localparam int unsigned     CNT_W   = f_clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_toggle;

    logic             w_sample;
    logic             w_cnt_done;

    assign w_sample   = r_sync2;
    assign w_cnt_done = (r_cnt == CNT_MAX);

    // Two-flop synchroniser; only r_sync2 is allowed to reach the FSM.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM. A change is accepted once the synchronised sample has held
    // the new value on the entry sample plus DB_CYCLES further samples.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_STABLE_LO;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            // Edge pulses last exactly one cycle unless re-asserted below.
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            unique case (r_state)
                ST_STABLE_LO: begin
                    if (w_sample) begin
                        r_state <= ST_WAIT_HI;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT_HI: begin
                    if (!w_sample) begin
                        // Glitch: drop back silently.
                        r_state <= ST_STABLE_LO;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state  <= ST_STABLE_HI;
                        r_cnt    <= '0;
                        r_level  <= 1'b1;
                        r_rise   <= 1'b1;
                        r_toggle <= ~r_toggle;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STABLE_HI: begin
                    if (!w_sample) begin
                        r_state <= ST_WAIT_LO;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT_LO: begin
                    if (w_sample) begin
                        r_state <= ST_STABLE_HI;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state <= ST_STABLE_LO;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_STABLE_LO;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_toggle = r_toggle;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Input stage for the rotating-LED design: synchronises and debounces each raw
// board button and provides a clean level, rise/fall pulses and a toggle state
// per channel. Channels are fully independent; all outputs are registered.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_reset       synchronous active-high reset
//   i_btn_raw     raw asynchronous buttons, bit i = channel i
//   o_btn_level   debounced level per channel
//   o_btn_rise    1-cycle pulse per channel on accepted press
//   o_btn_fall    1-cycle pulse per channel on accepted release
//   o_btn_toggle  per-channel state flipped on every accepted press
// -----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned NUM_BTN   = NUM_BTN_DEFAULT,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_BTN-1:0] i_btn_raw,
    output logic [NUM_BTN-1:0] o_btn_level,
    output logic [NUM_BTN-1:0] o_btn_rise,
    output logic [NUM_BTN-1:0] o_btn_fall,
    output logic [NUM_BTN-1:0] o_btn_toggle
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES)
        ) u_chan (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_raw    (i_btn_raw[g]),
            .o_level  (o_btn_level[g]),
            .o_rise   (o_btn_rise[g]),
            .o_fall   (o_btn_fall[g]),
            .o_toggle (o_btn_toggle[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Self-checking bench for button_conditioner with NUM_BTN=3, DB_CYCLES=4.
// Each step drives inputs, pushes the expected post-edge outputs to a queue,
// then pops and compares them just after the rising edge.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int unsigned NB  = 3;
    localparam int unsigned DB  = 4;
    // Step index (from the first edge that samples a change) at which the
    // debounced outputs update.
    localparam int          ACC = DB + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_rise;
    logic [NB-1:0] btn_fall;
    logic [NB-1:0] btn_toggle;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN   (NB),
        .DB_CYCLES (DB)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_btn_raw    (btn_raw),
        .o_btn_level  (btn_level),
        .o_btn_rise   (btn_rise),
        .o_btn_fall   (btn_fall),
        .o_btn_toggle (btn_toggle)
    );

    typedef struct packed {
        logic [NB-1:0] lvl;
        logic [NB-1:0] rise;
        logic [NB-1:0] fall;
        logic [NB-1:0] tog;
    } exp_t;

    typedef struct packed {
        logic [NB-1:0] raw;
        logic          rst;
        exp_t          exp;
    } vec_t;

    vec_t  vecs[$];
    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic step(input logic [NB-1:0] raw, input logic rst, input exp_t e,
                        input string name);
        exp_t  want;
        exp_t  got;
        string nm;
        btn_raw = raw;
        reset   = rst;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        got  = '{lvl: btn_level, rise: btn_rise, fall: btn_fall, tog: btn_toggle};
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got lvl=%b rise=%b fall=%b tog=%b, want lvl=%b rise=%b fall=%b tog=%b",
                     nm, $time, got.lvl, got.rise, got.fall, got.tog,
                     want.lvl, want.rise, want.fall, want.tog);
        end
    endtask

    // Expected outputs for step i of a clean held change: old values before
    // ACC, pulse at ACC, new values afterwards.
    function automatic exp_t std_exp(input int i, input logic [NB-1:0] lvl0,
                                     input logic [NB-1:0] lvl1, input logic [NB-1:0] rise,
                                     input logic [NB-1:0] fall, input logic [NB-1:0] tog0,
                                     input logic [NB-1:0] tog1);
        exp_t e;
        e.lvl  = (i < ACC) ? lvl0 : lvl1;
        e.rise = (i == ACC) ? rise : '0;
        e.fall = (i == ACC) ? fall : '0;
        e.tog  = (i < ACC) ? tog0 : tog1;
        return e;
    endfunction

    task automatic add_run(input logic [NB-1:0] raw, input int n, input logic [NB-1:0] lvl0,
                           input logic [NB-1:0] lvl1, input logic [NB-1:0] rise,
                           input logic [NB-1:0] fall, input logic [NB-1:0] tog0,
                           input logic [NB-1:0] tog1);
        for (int i = 0; i < n; i++) begin
            vecs.push_back('{raw: raw, rst: 1'b0,
                             exp: std_exp(i, lvl0, lvl1, rise, fall, tog0, tog1)});
        end
    endtask

    task automatic run_std(input logic [NB-1:0] raw, input int n, input logic [NB-1:0] lvl0,
                           input logic [NB-1:0] lvl1, input logic [NB-1:0] rise,
                           input logic [NB-1:0] fall, input logic [NB-1:0] tog0,
                           input logic [NB-1:0] tog1, input string name);
        for (int i = 0; i < n; i++) begin
            step(raw, 1'b0, std_exp(i, lvl0, lvl1, rise, fall, tog0, tog1), name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic          bp [5];
        exp_t          e;
        logic [NB-1:0] raw;

        reset   = 1'b1;
        btn_raw = '0;

        // ---- Table: reset, clean press/release on ch0 twice (toggle 0->1->0)
        vecs.push_back('{raw: 3'b000, rst: 1'b1, exp: '0});
        vecs.push_back('{raw: 3'b000, rst: 1'b1, exp: '0});
        add_run(3'b001, 8, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001);
        add_run(3'b000, 8, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001);
        add_run(3'b001, 8, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000);
        add_run(3'b000, 8, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].raw, vecs[i].rst, vecs[i].exp, "table");
        end

        // ---- Bounce on ch1: 1,0,1,1,0 then hold 1; rise 6 after last 0->1
        bp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 13; i++) begin
            raw    = (i < 5) ? {1'b0, bp[i], 1'b0} : 3'b010;
            e.lvl  = (i >= 11) ? 3'b010 : 3'b000;
            e.rise = (i == 11) ? 3'b010 : 3'b000;
            e.fall = 3'b000;
            e.tog  = (i >= 11) ? 3'b010 : 3'b000;
            step(raw, 1'b0, e, "bounce");
        end
        run_std(3'b000, 8, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010, "bounce_rel");

        // ---- Pulse width on ch2: 4 cycles rejected
        for (int i = 0; i < 10; i++) begin
            e = '{lvl: 3'b000, rise: 3'b000, fall: 3'b000, tog: 3'b010};
            step((i < 4) ? 3'b100 : 3'b000, 1'b0, e, "pulse4");
        end
        // 5 cycles accepted, then released: rise at 6, fall at 11
        for (int i = 0; i < 14; i++) begin
            e.lvl  = (i >= 6 && i < 11) ? 3'b100 : 3'b000;
            e.rise = (i == 6) ? 3'b100 : 3'b000;
            e.fall = (i == 11) ? 3'b100 : 3'b000;
            e.tog  = (i >= 6) ? 3'b110 : 3'b010;
            step((i < 5) ? 3'b100 : 3'b000, 1'b0, e, "pulse5");
        end

        // ---- Reset while ch0 is in WAIT_HI with cnt=2
        for (int i = 0; i < 5; i++) begin
            e = '{lvl: 3'b000, rise: 3'b000, fall: 3'b000, tog: 3'b110};
            step(3'b001, 1'b0, e, "pre_reset");
        end
        step(3'b001, 1'b1, '0, "mid_reset");
        run_std(3'b001, 8, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, "post_reset");
        run_std(3'b000, 8, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, "post_reset_rel");

        // ---- Simultaneous press and release on all channels
        run_std(3'b111, 8, 3'b000, 3'b111, 3'b111, 3'b000, 3'b001, 3'b110, "simul_press");
        run_std(3'b000, 8, 3'b111, 3'b000, 3'b000, 3'b111, 3'b110, 3'b110, "simul_rel");

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for the rotating-LED design.
- Takes raw, asynchronous, bouncing board push-buttons/switches (pause, rt, fast) and synchronises each one to clk, then debounces it.
- Produces, per channel, a clean level, single-cycle rise/fall pulses and a press-toggled state.
- These outputs feed the tick counter and the rotation counter directly.

Parameters:
- NUM_BTN, 3, number of independent button channels.
- DB_CYCLES, 250000, consecutive stable clk samples required after the first changed sample before a change is accepted. Minimum 2.
- CNT_W, clog2(DB_CYCLES), width of each channel's debounce counter. Derived; not overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  NUM_BTN  raw asynchronous button inputs; bit i = channel i.
- btn_level  out  NUM_BTN  debounced level per channel.
- btn_rise  out  NUM_BTN  1-cycle pulse when btn_level goes 0->1.
- btn_fall  out  NUM_BTN  1-cycle pulse when btn_level goes 1->0.
- btn_toggle  out  NUM_BTN  flips on every accepted press (rise).

Behaviour:
- Reset: synchroniser FFs, counters, FSM state (STABLE_LO), btn_level, btn_rise, btn_fall and btn_toggle all go to 0 at the next edge with reset=1.
- Reset mid-debounce abandons the pending change.
- A button held through reset is treated as a fresh press after release, with full latency.
- Synchroniser: 2-FF chain per channel (s1, s2). The FSM sees only s2.
- Per-channel FSM, 4 states:
  - STABLE_LO: s2=1 -> WAIT_HI, cnt<=0. Otherwise stay.
  - WAIT_HI: s2=0 -> STABLE_LO, cnt<=0 (glitch rejected, no pulse). s2=1 and cnt<DB_CYCLES-1 -> cnt++. s2=1 and cnt==DB_CYCLES-1 -> STABLE_HI, level<=1, rise<=1, toggle<=~toggle.
  - STABLE_HI: s2=0 -> WAIT_LO, cnt<=0.
  - WAIT_LO: the mirror of WAIT_HI. On acceptance go to STABLE_LO, level<=0, fall<=1. Toggle is unchanged.
- Acceptance rule: s2 must be high for DB_CYCLES+1 consecutive samples.
  - A raw pulse of DB_CYCLES cycles or fewer is rejected.
  - A raw pulse of DB_CYCLES+1 cycles or more is accepted.
- Latency: raw change first sampled by s1 at edge k -> btn_level changes after edge k+2+DB_CYCLES.
- btn_rise/btn_fall are asserted for exactly that one cycle, registered. They are never both high on one channel.
- Counter saturates at DB_CYCLES-1; it never wraps.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.
- All outputs are registered; there is no combinational path from btn_raw.

Decomposition:
- Shared package (button_pkg):
  - FSM state encoding constants ST_STABLE_LO=2'd0, ST_WAIT_HI=2'd1, ST_STABLE_HI=2'd2, ST_WAIT_LO=2'd3.
  - Default DB_CYCLES.
  - A clog2 function for CNT_W.
- Sub-module debounce_channel: one synchroniser + FSM + counter + toggle FF, with ports clk, reset, raw, level, rise, fall, toggle.
- button_conditioner generate-loops NUM_BTN instances.

Test Plan (bench overrides DB_CYCLES=4, NUM_BTN=3):
- Reset, then btn_raw=3'b001 held from edge 0 -> btn_level[0]=1 and btn_rise[0]=1 after edge 6 only. btn_rise[0] is low the next cycle. btn_toggle[0]=1. Other channels stay 0.
- Bounce: btn_raw[1] toggles 1,0,1,1,0 on successive cycles, then holds 1 -> no pulse during the bounce. Exactly one btn_rise[1], 6 cycles after the last 0->1 sample.
- Pulse width: btn_raw[2] high for 4 cycles -> no change. High for 5 cycles -> btn_level[2]=1, later btn_fall[2] once, btn_toggle[2]=1.
- Toggle: two clean press/release cycles on channel 0 -> btn_toggle[0] goes 0->1->0. btn_fall[0] does not alter btn_toggle[0].
- Reset mid-operation: assert reset while channel 0 is in WAIT_HI with cnt=2 -> all outputs 0 next edge. With raw still held, btn_rise[0] fires 6 cycles after reset deasserts.
- Simultaneous: btn_raw 000->111 on one edge -> btn_rise=3'b111 in the same single cycle. btn_level=3'b111.
